// File: rtl/sync_fifo_af.sv
// -----------------------------------------------------------------------------
// sync_fifo_af
//
// Single-clock FIFO with arbitrary (non power-of-two) depth, programmable
// almost-full / almost-empty thresholds, a first-word-fall-through or
// registered read port, a synchronous flush, and sticky overflow/underflow
// error flags. Intended for AXI channel buffers and stream adapters where
// back-pressure has to be raised before the FIFO is hard full.
//
// Parameters
//   W         data width in bits (>= 1)
//   D         depth in entries (>= 2, any integer)
//   UB        upper bit index of count (count is UB+1 bits wide)
//   AF_LEVEL  wr_almost_full when count >= AF_LEVEL (1..D)
//   AE_LEVEL  rd_almost_empty when count <= AE_LEVEL (0..D-1)
//   FWFT      1: head word shown on rd_data while not empty
//             0: rd_data is a register loaded on each accepted read
//
// Ports
//   clk              in   rising-edge clock
//   reset            in   synchronous, active-high reset
//   wr_en            in   write request
//   wr_data          in   write data (W bits)
//   wr_full          out  count == D
//   wr_almost_full   out  count >= AF_LEVEL
//   rd_en            in   read (pop) request
//   rd_data          out  read data (W bits)
//   rd_empty         out  count == 0
//   rd_almost_empty  out  count <= AE_LEVEL
//   count            out  number of stored entries, 0..D
//   flush            in   synchronous clear of contents
//   overflow         out  sticky: write attempted while full
//   underflow        out  sticky: read attempted while empty
//   clr_err          in   clears overflow and underflow
// -----------------------------------------------------------------------------
module sync_fifo_af #(
    parameter int W        = 8,
    parameter int D        = 16,
    parameter int UB       = $clog2(D),
    parameter int AF_LEVEL = D - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    output logic          wr_full,
    output logic          wr_almost_full,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          rd_empty,
    output logic          rd_almost_empty,
    output logic [UB:0]   count,
    input  logic          flush,
    output logic          overflow,
    output logic          underflow,
    input  logic          clr_err
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    // Pointer width only needs to address 0..D-1; D >= 2 keeps this >= 1.
    localparam int PW = (D > 1) ? $clog2(D) : 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(D - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [UB:0]   CNT_FULL = (UB + 1)'(D);
    localparam logic [UB:0]   CNT_ONE  = (UB + 1)'(1);
    localparam logic [UB:0]   CNT_AF   = (UB + 1)'(AF_LEVEL);
    localparam logic [UB:0]   CNT_AE   = (UB + 1)'(AE_LEVEL);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    generate
        if (W < 1) begin : g_bad_width
            $error("sync_fifo_af: W must be >= 1");
        end
        if (D < 2) begin : g_bad_depth
            $error("sync_fifo_af: D must be >= 2");
        end
        if ((AF_LEVEL < 1) || (AF_LEVEL > D)) begin : g_bad_af
            $error("sync_fifo_af: AF_LEVEL must be within 1..D");
        end
        if ((AE_LEVEL < 0) || (AE_LEVEL > D - 1)) begin : g_bad_ae
            $error("sync_fifo_af: AE_LEVEL must be within 0..D-1");
        end
        if ((64'd1 << (UB + 1)) <= 64'(D)) begin : g_bad_ub
            $error("sync_fifo_af: UB too small to hold a count of D");
        end
        if ((FWFT != 0) && (FWFT != 1)) begin : g_bad_fwft
            $error("sync_fifo_af: FWFT must be 0 or 1");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [W-1:0]  r_mem [0:D-1];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [UB:0]   r_count;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_accept;
    logic          w_rd_accept;
    logic [PW-1:0] w_wr_ptr_next;
    logic [PW-1:0] w_rd_ptr_next;

    // -------------------------------------------------------------------------
    // Status decode
    // -------------------------------------------------------------------------
    // Every flag is a pure decode of the registered count, so none of them has
    // a combinational path back from wr_en / rd_en. This keeps the flags safe
    // to use as back-pressure in the same cycle by the upstream producer.
    assign w_full          = (r_count == CNT_FULL);
    assign w_empty         = (r_count == '0);

    assign wr_full         = w_full;
    assign rd_empty        = w_empty;
    assign wr_almost_full  = (r_count >= CNT_AF);
    assign rd_almost_empty = (r_count <= CNT_AE);
    assign count           = r_count;
    assign overflow        = r_overflow;
    assign underflow       = r_underflow;

    // -------------------------------------------------------------------------
    // Access qualification
    // -------------------------------------------------------------------------
    // A write is refused whenever the FIFO is full, even if a read frees a
    // slot in the same cycle; there is no write-through path. Symmetrically a
    // read is refused while empty even if a write lands in the same cycle.
    assign w_wr_accept = wr_en & ~w_full;
    assign w_rd_accept = rd_en & ~w_empty;

    // Pointers wrap with an explicit compare because D need not be a power
    // of two, so plain bit truncation would walk into unused addresses.
    assign w_wr_ptr_next = (r_wr_ptr == PTR_LAST) ? '0 : (r_wr_ptr + PTR_ONE);
    assign w_rd_ptr_next = (r_rd_ptr == PTR_LAST) ? '0 : (r_rd_ptr + PTR_ONE);

    // -------------------------------------------------------------------------
    // Storage array
    // -------------------------------------------------------------------------
    // No reset on the array itself: contents are only ever visible through the
    // read pointer, and count/pointers define which entries are meaningful.
    // A flush cycle discards its write, so the array is left untouched then.
    always_ff @(posedge clk) begin
        if (!reset && !flush && w_wr_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Write pointer
    // -------------------------------------------------------------------------
    // Reset and flush both return to entry 0 so the first accepted write after
    // either always lands in slot 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
        end else if (w_wr_accept) begin
            r_wr_ptr <= w_wr_ptr_next;
        end
    end

    // -------------------------------------------------------------------------
    // Read pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
        end else if (w_rd_accept) begin
            r_rd_ptr <= w_rd_ptr_next;
        end
    end

    // -------------------------------------------------------------------------
    // Occupancy count
    // -------------------------------------------------------------------------
    // Because accepts are already gated by full/empty, the count can only step
    // up from below D and down from above 0, so it never leaves 0..D.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_wr_accept && !w_rd_accept) begin
            r_count <= r_count + CNT_ONE;
        end else if (!w_wr_accept && w_rd_accept) begin
            r_count <= r_count - CNT_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky error flags
    // -------------------------------------------------------------------------
    // A new error in the same cycle as clr_err wins, so a clear can never hide
    // an event that happened while it was being asserted. Flush neither sets
    // nor clears these; the error conditions are judged on the raw requests
    // against the registered full/empty state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (wr_en && w_full) begin
            r_overflow <= 1'b1;
        end else if (clr_err) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_underflow <= 1'b0;
        end else if (rd_en && w_empty) begin
            r_underflow <= 1'b1;
        end else if (clr_err) begin
            r_underflow <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Read port
    // -------------------------------------------------------------------------
    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally from the array; the
            // consumer takes it in the same cycle it raises rd_en. The value
            // is meaningless while rd_empty is high.
            assign rd_data = r_mem[r_rd_ptr];
        end else begin : g_registered
            logic [W-1:0] r_rd_data;

            // Registered read: the popped word appears the cycle after the
            // accepted read and then holds. A flush cycle discards the read,
            // so the register keeps its previous value across a flush.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_rd_data <= '0;
                end else if (!flush && w_rd_accept) begin
                    r_rd_data <= r_mem[r_rd_ptr];
                end
            end

            assign rd_data = r_rd_data;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_af.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_af
//
// Drives three sync_fifo_af instances from one shared input stream:
//   inst 0: D=5,  AF=4,  AE=1, FWFT=1
//   inst 1: D=16, AF=14, AE=2, FWFT=1
//   inst 2: D=4,  AF=2,  AE=1, FWFT=0
// A list-based reference model predicts each instance's state after every
// edge; expectations go into a queue and a separate negedge monitor pops and
// compares them against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_sync_fifo_af;

    localparam int NI = 3;
    localparam int PD  [NI] = '{5, 16, 4};
    localparam int PAF [NI] = '{4, 14, 2};
    localparam int PAE [NI] = '{1, 2, 1};
    localparam int PF  [NI] = '{1, 1, 0};

    typedef struct {
        int         cyc;
        int         inst;
        int         cnt;
        bit         full;
        bit         af;
        bit         empty;
        bit         ae;
        bit         ov;
        bit         un;
        bit         chkData;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_en = 1'b0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;

    logic [3:0] cntA;
    logic [4:0] cntB;
    logic [2:0] cntC;
    logic [7:0] rdA, rdB, rdC;
    logic [2:0] fullV, afV, emptyV, aeV, ovV, unV;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;
    bit   leftoverChecked = 1'b0;
    exp_t expQ[$];
    exp_t monE;

    // Reference model: each FIFO is an ordered list, index 0 is the head.
    logic [7:0] mData [NI][16];
    int         mCnt  [NI];
    logic [7:0] mRd   [NI];
    bit         mOv   [NI];
    bit         mUn   [NI];

    // Free-running clock and cycle stamp used to align expectations.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sync_fifo_af #(.W(8), .D(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(1)) u_dutA (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(fullV[0]), .wr_almost_full(afV[0]), .rd_en(rd_en),
        .rd_data(rdA), .rd_empty(emptyV[0]), .rd_almost_empty(aeV[0]),
        .count(cntA), .flush(flush), .overflow(ovV[0]),
        .underflow(unV[0]), .clr_err(clr_err)
    );

    sync_fifo_af #(.W(8), .D(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u_dutB (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(fullV[1]), .wr_almost_full(afV[1]), .rd_en(rd_en),
        .rd_data(rdB), .rd_empty(emptyV[1]), .rd_almost_empty(aeV[1]),
        .count(cntB), .flush(flush), .overflow(ovV[1]),
        .underflow(unV[1]), .clr_err(clr_err)
    );

    sync_fifo_af #(.W(8), .D(4), .AF_LEVEL(2), .AE_LEVEL(1), .FWFT(0)) u_dutC (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .wr_full(fullV[2]), .wr_almost_full(afV[2]), .rd_en(rd_en),
        .rd_data(rdC), .rd_empty(emptyV[2]), .rd_almost_empty(aeV[2]),
        .count(cntC), .flush(flush), .overflow(ovV[2]),
        .underflow(unV[2]), .clr_err(clr_err)
    );

    // One comparison; only the monitor calls this.
    task automatic checkOutput(input string name, input int inst, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("[TB] FAIL inst%0d cyc%0d %s: got %0d expected %0d", inst, cyc, name, got, want);
        end
    endtask

    // Advance the model of one instance across one clock edge.
    task automatic modelStep(input int i, input bit rs, input bit we, input logic [7:0] wd,
                             input bit re, input bit fl, input bit ce);
        bit isFull, isEmpty;
        if (rs) begin
            mCnt[i] = 0;
            mRd[i]  = 8'h00;
            mOv[i]  = 1'b0;
            mUn[i]  = 1'b0;
        end else begin
            isFull  = (mCnt[i] == PD[i]);
            isEmpty = (mCnt[i] == 0);
            if (ce) begin
                mOv[i] = 1'b0;
                mUn[i] = 1'b0;
            end
            if (we && isFull)  mOv[i] = 1'b1;
            if (re && isEmpty) mUn[i] = 1'b1;
            if (fl) begin
                mCnt[i] = 0;
            end else begin
                if (re && !isEmpty) begin
                    if (PF[i] == 0) mRd[i] = mData[i][0];
                    for (int k = 0; k < mCnt[i] - 1; k++) mData[i][k] = mData[i][k + 1];
                    mCnt[i]--;
                end
                if (we && !isFull) begin
                    mData[i][mCnt[i]] = wd;
                    mCnt[i]++;
                end
            end
        end
    endtask

    // Drive one cycle of inputs and queue the predicted post-edge state.
    task automatic applyStimulus(input bit rs, input bit we, input logic [7:0] wd,
                                 input bit re, input bit fl, input bit ce);
        exp_t e;
        @(posedge clk);
        #1;
        reset   = rs;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        flush   = fl;
        clr_err = ce;
        for (int i = 0; i < NI; i++) begin
            modelStep(i, rs, we, wd, re, fl, ce);
            e.cyc     = cyc + 1;
            e.inst    = i;
            e.cnt     = mCnt[i];
            e.full    = (mCnt[i] == PD[i]);
            e.af      = (mCnt[i] >= PAF[i]);
            e.empty   = (mCnt[i] == 0);
            e.ae      = (mCnt[i] <= PAE[i]);
            e.ov      = mOv[i];
            e.un      = mUn[i];
            if (PF[i] != 0) begin
                e.chkData = (mCnt[i] > 0);
                e.data    = mData[i][0];
            end else begin
                e.chkData = 1'b1;
                e.data    = mRd[i];
            end
            expQ.push_back(e);
        end
    endtask

    task automatic wrOnly(input logic [7:0] d);  applyStimulus(0, 1, d, 0, 0, 0); endtask
    task automatic rdOnly();                    applyStimulus(0, 0, 8'h00, 1, 0, 0); endtask
    task automatic wrRd(input logic [7:0] d);    applyStimulus(0, 1, d, 1, 0, 0); endtask
    task automatic idle();                      applyStimulus(0, 0, 8'h00, 0, 0, 0); endtask

    // Monitor: at mid-cycle compare every expectation stamped for this cycle.
    always @(negedge clk) begin
        int gCnt;
        logic [7:0] gData;
        while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
            monE = expQ.pop_front();
            if (monE.cyc < cyc) begin
                checkOutput("stale_expectation", monE.inst, monE.cyc, cyc);
            end else begin
                case (monE.inst)
                    0:       begin gCnt = int'(cntA); gData = rdA; end
                    1:       begin gCnt = int'(cntB); gData = rdB; end
                    default: begin gCnt = int'(cntC); gData = rdC; end
                endcase
                checkOutput("count",           monE.inst, gCnt, monE.cnt);
                checkOutput("wr_full",         monE.inst, int'(fullV[monE.inst]),  int'(monE.full));
                checkOutput("wr_almost_full",  monE.inst, int'(afV[monE.inst]),    int'(monE.af));
                checkOutput("rd_empty",        monE.inst, int'(emptyV[monE.inst]), int'(monE.empty));
                checkOutput("rd_almost_empty", monE.inst, int'(aeV[monE.inst]),    int'(monE.ae));
                checkOutput("overflow",        monE.inst, int'(ovV[monE.inst]),    int'(monE.ov));
                checkOutput("underflow",       monE.inst, int'(unV[monE.inst]),    int'(monE.un));
                if (monE.chkData) begin
                    checkOutput("rd_data", monE.inst, int'(gData), int'(monE.data));
                end
            end
        end
        if (done && !leftoverChecked) begin
            leftoverChecked = 1'b1;
            checkOutput("unconsumed_expectations", 0, expQ.size(), 0);
        end
    end

    initial begin
        bit phaseFill;
        for (int i = 0; i < NI; i++) begin
            mCnt[i] = 0;
            mRd[i]  = 8'h00;
            mOv[i]  = 1'b0;
            mUn[i]  = 1'b0;
        end

        // Reset held for a few cycles.
        repeat (2) applyStimulus(1, 0, 8'h00, 0, 0, 0);

        // Fill with 0x11..0x15, then read five back.
        for (int i = 0; i < 5; i++) wrOnly(8'(8'h11 + i));
        repeat (5) rdOnly();
        applyStimulus(0, 0, 8'h00, 0, 0, 1);

        // Wrap: 3 writes, 2 reads, then 6 simultaneous write/read cycles.
        repeat (3) wrOnly(8'h30);
        repeat (2) rdOnly();
        for (int i = 0; i < 6; i++) wrRd(8'(8'hA0 + i));
        repeat (2) rdOnly();

        // Full plus simultaneous wr/rd, drain, read on empty, error clearing.
        for (int i = 0; i < 5; i++) wrOnly(8'(8'h40 + i));
        wrRd(8'h4F);
        repeat (5) rdOnly();
        rdOnly();
        applyStimulus(0, 0, 8'h00, 0, 0, 1);
        applyStimulus(0, 0, 8'h00, 1, 0, 1);
        applyStimulus(0, 0, 8'h00, 0, 0, 1);

        // Empty boundary: simultaneous wr/rd on an empty FIFO.
        wrRd(8'h55);
        rdOnly();

        // Threshold sweep for the deep instance: fill to 16, then drain.
        for (int i = 0; i < 16; i++) wrOnly(8'(8'h60 + i));
        repeat (17) rdOnly();
        applyStimulus(0, 0, 8'h00, 0, 0, 1);

        // Flush with a simultaneous write, then write/read a fresh word.
        repeat (3) wrOnly(8'h70);
        applyStimulus(0, 1, 8'h71, 0, 1, 0);
        wrOnly(8'h77);
        rdOnly();
        idle();

        // Registered-read hold, then reset in the middle of a sequence.
        wrOnly(8'h5A);
        wrOnly(8'hC3);
        rdOnly();
        repeat (2) idle();
        rdOnly();
        wrOnly(8'h99);
        applyStimulus(1, 1, 8'hEE, 1, 0, 0);
        wrOnly(8'h12);
        rdOnly();

        // Randomized traffic with alternating fill-biased and drain-biased phases.
        for (int n = 0; n < 3000; n++) begin
            phaseFill = ((n / 64) % 2) == 0;
            applyStimulus(($urandom_range(0, 399) == 0),
                          phaseFill ? ($urandom_range(0, 99) < 75) : ($urandom_range(0, 99) < 35),
                          8'($urandom),
                          phaseFill ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 75),
                          ($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 19) == 0));
        end

        idle();
        repeat (3) @(posedge clk);
        done = 1'b1;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
